ps2_tx: RTL and testbench
=========================

Name: ps2_tx

Overview:
- PS/2 host-to-device transmitter for the KSM terminal: the opposite direction to the existing PS/2 keyboard receiver.
- Lets the monitor firmware send command bytes to the keyboard, e.g. ED (set LEDs), F4 (enable), FF (reset).
- Wishbone slave at 171004–171006, mapped beside the receiver at 171000.
- Drives the open-drain PS/2 clock and data lines, frames bytes (start, 8 data bits, odd parity, stop), checks the device ACK, and raises a vectored interrupt on completion.

Parameters:
- CLKFREQ, 50000000, wb_clk_i frequency in Hz.
- INHIBIT_US, 100, clock-inhibit time before request-to-send, in µs.
- TIMEOUT_MS, 15, maximum whole-frame duration before abort, in ms.
- FILTER, 8, number of consecutive equal samples needed to accept a PS/2 line level.

Ports:
- wb_clk_i  in  1  system clock (clk50).
- wb_rst_ni  in  1  reset, asynchronous, active-low.
- wb_adr_i  in  16  Wishbone address; only bit 1 is decoded.
- wb_dat_i  in  16  Wishbone write data.
- wb_dat_o  out  16  Wishbone read data.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1  Wishbone cycle, strobe, write enable.
- wb_sel_i  in  2  Wishbone byte selects.
- wb_ack_o  out  1  Wishbone acknowledge.
- irq  out  1  interrupt request to wbc_vic.
- iack  in  1  interrupt acknowledge from wbc_vic.
- ps2_clk_i, ps2_dat_i  in  1  sensed line levels.
- ps2_clk_oe, ps2_dat_oe  out  1  1 = pull the line low (open-drain drive).
- rx_inhibit  out  1  high while busy; the receiver ignores frames while it is high.

Behaviour:
- Reset values: all outputs 0; wb_dat_o 0; state IDLE; RDY=1; IE=0; NAK=0; TMO=0; data register 0.
- Wishbone:
  - wb_ack_o is registered and one cycle long: it asserts the cycle after cyc&stb and is suppressed while already high.
  - adr[1]=0 selects CSR; adr[1]=1 selects DATA.
  - Reads return a registered value.
- CSR:
  - bit7 RDY (ro), bit6 IE (rw), bit1 TMO (ro), bit0 NAK (ro).
  - A write with sel[0]=1 updates IE.
- DATA:
  - A write with sel[0]=1 while RDY=1 latches wb_dat_i[7:0], clears NAK, TMO and irq, sets RDY=0, and starts the frame.
  - A write while RDY=0 is acked but ignored.
  - A read returns {8'b0, last byte}.
- Line inputs: 2-FF synchroniser, then a FILTER-sample glitch filter. A falling edge is a filtered 1→0 transition.
- State machine:
  - IDLE: waits for a start.
  - INHIBIT: clk_oe=1 for INHIBIT_US*CLKFREQ/1e6 cycles (5000 at defaults).
  - RTS: dat_oe=1, clk_oe=0. Waits for the first falling edge; the start bit (0) is already on the line.
  - SHIFT: on each falling edge, present the next bit.
    - Bits 0..7 go out LSB first, then parity = ~^data.
    - A 0 bit sets dat_oe=1; a 1 bit sets dat_oe=0.
    - After the parity bit's edge, release data for the stop bit: dat_oe=0.
  - ACKW: on the next falling edge, sample data. 0 = ACK; 1 sets NAK.
  - DONE: waits for filtered clk=1 and dat=1, then goes to IDLE and sets RDY=1.
- Timeout:
  - A frame timer runs from INHIBIT entry.
  - Reaching TIMEOUT_MS*CLKFREQ/1000 cycles in any non-IDLE state sets TMO=1, releases both lines, and goes to IDLE with RDY=1.
- Interrupt:
  - irq is set on any busy→idle transition if IE=1, and on an IE 0→1 write while RDY=1.
  - irq is cleared by iack, by IE=0, or by a DATA write.
  - If iack and a set event occur in the same cycle, set wins.
- rx_inhibit = ~RDY.
- Frame counter is 4 bits, counting 0..9; no wrap-around is possible.
- wb_rst_ni low mid-frame: lines are released immediately (asynchronous clear of the *_oe outputs).

Decomposition:
- Shared package:
  - state encoding;
  - register offsets (CSR=0, DATA=2);
  - CSR bit positions;
  - cycle-count constants derived from CLKFREQ.
- One sub-module, ps2_line_filter: synchroniser plus glitch filter plus falling-edge detector. Instantiate it twice, once for clk and once for data.

Test Plan:
- Keyboard model ACKs. Write DATA=0xED → clk held low ~5000 cycles; then bits 1,0,1,1,0,1,1,1, parity 1, stop released; RDY=1, NAK=0 after ACK.
- Write 0xF4 with the model driving data=1 at the ACK edge → NAK=1, RDY=1, irq=1 if IE=1, cleared by iack pulse.
- Model never clocks after RTS → TMO=1 at 750000 cycles, both *_oe=0, RDY=1.
- Second DATA write (0x55) while busy → acked, frame still carries the first byte; DATA read returns the first byte.
- IE written 1 while idle → irq=1 next cycle; a DATA write clears it; 2-cycle glitches on ps2_clk_i produce no bit shifts.
- Assert wb_rst_ni mid-SHIFT → *_oe=0 asynchronously, CSR reads 0x0080 after release.

Source files
------------

// File: rtl/ps2_tx_pkg.sv
// rtl/ps2_tx_pkg.sv - shared types and constants for the PS/2 host-to-device transmitter
package ps2_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SHIFT,
        ST_ACKW,
        ST_DONE
    } state_t;

    localparam logic [15:0] REG_CSR  = 16'h0000;
    localparam logic [15:0] REG_DATA = 16'h0002;

    localparam int CSR_RDY = 7;
    localparam int CSR_IE  = 6;
    localparam int CSR_TMO = 1;
    localparam int CSR_NAK = 0;

    // clkfreq * units / per_sec, done in 64 bits because 100 us * 50 MHz overflows 32
    function automatic logic [31:0] scale_cycles(input longint unsigned clkfreq,
                                                 input longint unsigned units,
                                                 input longint unsigned per_sec);
        return 32'((clkfreq * units) / per_sec);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - PS/2 line synchroniser, glitch filter and falling-edge detector
// clk, rst_n : system clock, async active-low reset
// line       : raw sensed line level
// level      : filtered level (idle high)
// fall       : one-cycle pulse when the filtered level goes 1 -> 0
module ps2_line_filter #(
    parameter int FILTER = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic level,
    output logic fall
);

    localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // cnt counts consecutive synchronised samples that disagree with level;
    // the FILTER-th one in a row flips the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], line};
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER - 1)) begin
                level <= sync[1];
                fall  <= level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - PS/2 host-to-device transmitter with Wishbone CSR/DATA registers
// wb_*              : Wishbone slave, adr[1] selects CSR (0) or DATA (1)
// irq, iack         : vectored interrupt request / acknowledge
// ps2_clk_i/dat_i   : sensed line levels
// ps2_clk_oe/dat_oe : 1 pulls the open-drain line low
// rx_inhibit        : high while a frame is in progress
module ps2_tx
    import ps2_tx_pkg::*;
#(
    parameter int CLKFREQ    = 50_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_MS = 15,
    parameter int FILTER     = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [15:0] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic        irq,
    input  logic        iack,
    input  logic        ps2_clk_i,
    input  logic        ps2_dat_i,
    output logic        ps2_clk_oe,
    output logic        ps2_dat_oe,
    output logic        rx_inhibit
);

    localparam logic [31:0] INH_CYC = scale_cycles(64'(CLKFREQ), 64'(INHIBIT_US), 64'd1_000_000);
    localparam logic [31:0] TMO_CYC = scale_cycles(64'(CLKFREQ), 64'(TIMEOUT_MS), 64'd1_000);

    state_t      state, state_nxt;
    logic        clk_oe_nxt, dat_oe_nxt;
    logic [31:0] timer, timer_nxt;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  data_reg;
    logic        rdy, ie, nak, tmo;
    logic        nak_set, tmo_set, finish;
    logic        clk_level, clk_fall, dat_level, unused_dat_fall;
    logic        req, wr, sel_data, sel_csr, csr_wr, start;
    logic        irq_set, irq_clr, tx_bit;
    logic [15:0] csr_val;
    logic        unused;

    assign unused = ^{wb_adr_i[15:2], wb_adr_i[0], wb_dat_i[15:8], wb_sel_i[1], unused_dat_fall};

    ps2_line_filter #(.FILTER(FILTER)) u_clk_filt (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .line  (ps2_clk_i),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_line_filter #(.FILTER(FILTER)) u_dat_filt (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .line  (ps2_dat_i),
        .level (dat_level),
        .fall  (unused_dat_fall)
    );

    assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr       = req & wb_we_i & wb_sel_i[0];
    assign sel_data = (wb_adr_i[1] == REG_DATA[1]);
    assign sel_csr  = (wb_adr_i[1] == REG_CSR[1]);
    assign csr_wr   = wr & sel_csr;
    assign start    = wr & sel_data & rdy;

    // bit_cnt 0..7 are data bits LSB first, 8 is odd parity
    assign tx_bit = (bit_cnt < 4'd8) ? data_reg[bit_cnt[2:0]] : ~^data_reg;

    always_comb begin
        csr_val          = '0;
        csr_val[CSR_RDY] = rdy;
        csr_val[CSR_IE]  = ie;
        csr_val[CSR_TMO] = tmo;
        csr_val[CSR_NAK] = nak;
    end

    always_comb begin
        state_nxt   = state;
        clk_oe_nxt  = ps2_clk_oe;
        dat_oe_nxt  = ps2_dat_oe;
        timer_nxt   = timer;
        bit_cnt_nxt = bit_cnt;
        nak_set     = 1'b0;
        tmo_set     = 1'b0;
        if (state != ST_IDLE) begin
            timer_nxt = timer + 32'd1;
        end
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt   = ST_INHIBIT;
                    timer_nxt   = '0;
                    bit_cnt_nxt = '0;
                    clk_oe_nxt  = 1'b1;
                    dat_oe_nxt  = 1'b0;
                end
            end
            ST_INHIBIT: begin
                if (timer == INH_CYC - 32'd1) begin
                    state_nxt  = ST_RTS;
                    clk_oe_nxt = 1'b0;
                    dat_oe_nxt = 1'b1;
                end
            end
            ST_RTS: begin
                // start bit is already on the line; the first device clock asks for bit 0
                if (clk_fall) begin
                    state_nxt   = ST_SHIFT;
                    dat_oe_nxt  = ~tx_bit;
                    bit_cnt_nxt = 4'd1;
                end
            end
            ST_SHIFT: begin
                if (clk_fall) begin
                    if (bit_cnt == 4'd9) begin
                        state_nxt  = ST_ACKW;
                        dat_oe_nxt = 1'b0;
                    end else begin
                        dat_oe_nxt  = ~tx_bit;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end
                end
            end
            ST_ACKW: begin
                if (clk_fall) begin
                    nak_set   = dat_level;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (clk_level && dat_level) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (state != ST_IDLE && timer == TMO_CYC - 32'd1) begin
            tmo_set    = 1'b1;
            state_nxt  = ST_IDLE;
            clk_oe_nxt = 1'b0;
            dat_oe_nxt = 1'b0;
        end
    end

    assign finish = (state != ST_IDLE) && (state_nxt == ST_IDLE);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= ST_IDLE;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            timer      <= '0;
            bit_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            ps2_clk_oe <= clk_oe_nxt;
            ps2_dat_oe <= dat_oe_nxt;
            timer      <= timer_nxt;
            bit_cnt    <= bit_cnt_nxt;
        end
    end

    // set events beat clear events (iack in the same cycle as completion keeps irq)
    assign irq_set = (finish & ie) | (csr_wr & wb_dat_i[CSR_IE] & ~ie & rdy);
    assign irq_clr = iack | (csr_wr & ~wb_dat_i[CSR_IE]) | start;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            rdy      <= 1'b1;
            ie       <= 1'b0;
            nak      <= 1'b0;
            tmo      <= 1'b0;
            data_reg <= '0;
            irq      <= 1'b0;
        end else begin
            wb_ack_o <= req;
            if (req && !wb_we_i) begin
                wb_dat_o <= sel_data ? {8'h00, data_reg} : csr_val;
            end
            if (csr_wr) begin
                ie <= wb_dat_i[CSR_IE];
            end
            if (start) begin
                data_reg <= wb_dat_i[7:0];
                rdy      <= 1'b0;
                nak      <= 1'b0;
                tmo      <= 1'b0;
            end else begin
                if (finish)  rdy <= 1'b1;
                if (nak_set) nak <= 1'b1;
                if (tmo_set) tmo <= 1'b1;
            end
            irq <= irq_set | (irq & ~irq_clr);
        end
    end

    assign rx_inhibit = ~rdy;

endmodule

// File: tb/tb_ps2_tx.sv
// tb/tb_ps2_tx.sv - directed self-checking bench for ps2_tx with a PS/2 keyboard model
module tb_ps2_tx;

    localparam int TMO_CYC = 15000;
    localparam int HALF    = 25;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] wb_adr = '0;
    logic [15:0] wb_dat = '0;
    logic [15:0] wb_dat_o;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic [1:0]  wb_sel = '0;
    logic        wb_ack_o;
    logic        irq;
    logic        iack = 1'b0;
    logic        ps2_clk_i, ps2_dat_i;
    logic        ps2_clk_oe, ps2_dat_oe;
    logic        rx_inhibit;
    logic        kb_clk_low = 1'b0;
    logic        kb_dat_low = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign ps2_clk_i = ~(ps2_clk_oe | kb_clk_low);
    assign ps2_dat_i = ~(ps2_dat_oe | kb_dat_low);

    ps2_tx #(
        .CLKFREQ    (1_000_000),
        .INHIBIT_US (100),
        .TIMEOUT_MS (15),
        .FILTER     (8)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wb_adr_i   (wb_adr),
        .wb_dat_i   (wb_dat),
        .wb_dat_o   (wb_dat_o),
        .wb_cyc_i   (wb_cyc),
        .wb_stb_i   (wb_stb),
        .wb_we_i    (wb_we),
        .wb_sel_i   (wb_sel),
        .wb_ack_o   (wb_ack_o),
        .irq        (irq),
        .iack       (iack),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_dat_i  (ps2_dat_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .rx_inhibit (rx_inhibit)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic we, input logic [15:0] adr, input logic [15:0] wdat,
                           output logic [15:0] rdat);
        int n;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_we  = we;
        wb_adr = adr;
        wb_dat = wdat;
        wb_sel = 2'b01;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!wb_ack_o && n < 10);
        check("wb_ack", 32'(wb_ack_o), 1);
        rdat   = wb_dat_o;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
    endtask

    task automatic iack_pulse();
        iack = 1'b1;
        tick(1);
        iack = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (rx_inhibit && n < 500) begin
            tick(1);
            n++;
        end
        check(tag, 32'(rx_inhibit), 0);
    endtask

    // bits[0] start, bits[8:1] data, bits[9] parity, bits[10] stop, sampled on rising clock
    task automatic kb_frame(input bit nak, input bit glitch, output int inh, output logic [10:0] bits);
        int n;
        bits = '0;
        inh  = 0;
        n    = 0;
        while (!ps2_clk_oe && n < 50) begin
            tick(1);
            n++;
        end
        while (ps2_clk_oe && inh < 1000) begin
            tick(1);
            inh++;
        end
        check("rts_dat_oe", 32'(ps2_dat_oe), 1);
        if (glitch) begin
            tick(15);
            kb_clk_low = 1'b1;
            tick(2);
            kb_clk_low = 1'b0;
            tick(20);
            check("rts_glitch_dat_oe", 32'(ps2_dat_oe), 1);
        end
        tick(HALF);
        bits[0] = ps2_dat_i;
        for (int i = 1; i <= 10; i++) begin
            kb_clk_low = 1'b1;
            tick(HALF);
            kb_clk_low = 1'b0;
            tick(3);
            bits[i] = ps2_dat_i;
            if (glitch) begin
                tick(11);
                kb_clk_low = 1'b1;
                tick(2);
                kb_clk_low = 1'b0;
                tick(9);
            end else begin
                tick(22);
            end
        end
        kb_dat_low = !nak;
        tick(HALF);
        kb_clk_low = 1'b1;
        tick(HALF);
        kb_clk_low = 1'b0;
        tick(2);
        kb_dat_low = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd;
        logic [10:0] bits;
        int          inh;
        int          n;

        rst_n = 1'b0;
        tick(5);
        rst_n = 1'b1;
        check("rst_outputs", 32'({wb_ack_o, irq, ps2_clk_oe, ps2_dat_oe, rx_inhibit}), 0);
        check("rst_wb_dat_o", 32'(wb_dat_o), 0);
        tick(2);
        wb_xfer(1'b0, 16'h0000, 16'h0000, rd);
        check("rst_csr", 32'(rd), 32'h0080);
        tick(1);
        check("ack_one_cycle", 32'(wb_ack_o), 0);
        wb_xfer(1'b0, 16'h0002, 16'h0000, rd);
        check("rst_data", 32'(rd), 0);

        // IE 0->1 while idle raises irq
        wb_xfer(1'b1, 16'h0000, 16'h0040, rd);
        check("ie_set_irq", 32'(irq), 1);
        wb_xfer(1'b0, 16'h0000, 16'h0000, rd);
        check("csr_ie", 32'(rd), 32'h00C0);

        // 0xED with ACK and clock glitches
        wb_xfer(1'b1, 16'h0002, 16'h00ED, rd);
        check("data_wr_clears_irq", 32'(irq), 0);
        check("busy_rx_inhibit", 32'(rx_inhibit), 1);
        kb_frame(1'b0, 1'b1, inh, bits);
        check("inhibit_len", 32'(inh), 100);
        check("ed_start_bit", 32'(bits[0]), 0);
        check("ed_frame", 32'(bits[10:1]), 32'h3ED);
        wait_idle("ed_done");
        check("ed_irq", 32'(irq), 1);
        iack_pulse();
        check("ed_iack", 32'(irq), 0);
        wb_xfer(1'b0, 16'h0000, 16'h0000, rd);
        check("ed_csr", 32'(rd), 32'h00C0);

        // 0xF4 with a write while busy, device NAKs
        wb_xfer(1'b1, 16'h0002, 16'h00F4, rd);
        wb_xfer(1'b1, 16'h0002, 16'h0055, rd);
        wb_xfer(1'b0, 16'h0002, 16'h0000, rd);
        check("busy_data_rd", 32'(rd), 32'h00F4);
        kb_frame(1'b1, 1'b0, inh, bits);
        check("f4_start_bit", 32'(bits[0]), 0);
        check("f4_frame", 32'(bits[10:1]), 32'h2F4);
        wait_idle("f4_done");
        check("f4_irq", 32'(irq), 1);
        iack_pulse();
        check("f4_iack", 32'(irq), 0);
        wb_xfer(1'b0, 16'h0000, 16'h0000, rd);
        check("f4_csr_nak", 32'(rd), 32'h00C1);

        // device never clocks: frame timeout
        wb_xfer(1'b1, 16'h0002, 16'h00FF, rd);
        tick(TMO_CYC - 100);
        check("tmo_still_busy", 32'(rx_inhibit), 1);
        check("tmo_rts_dat_oe", 32'(ps2_dat_oe), 1);
        tick(200);
        check("tmo_rdy", 32'(rx_inhibit), 0);
        check("tmo_lines", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
        check("tmo_irq", 32'(irq), 1);
        wb_xfer(1'b0, 16'h0000, 16'h0000, rd);
        check("tmo_csr", 32'(rd), 32'h00C2);
        iack_pulse();

        // reset in the middle of the data bits
        wb_xfer(1'b1, 16'h0002, 16'h0000, rd);
        n = 0;
        while (!(ps2_dat_oe && !ps2_clk_oe) && n < 300) begin
            tick(1);
            n++;
        end
        check("rst_test_rts", 32'({ps2_dat_oe, ps2_clk_oe}), 32'h2);
        for (int i = 0; i < 3; i++) begin
            kb_clk_low = 1'b1;
            tick(HALF);
            kb_clk_low = 1'b0;
            tick(HALF);
        end
        check("pre_rst_dat_oe", 32'(ps2_dat_oe), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_lines", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
        check("async_rst_rdy", 32'(rx_inhibit), 0);
        tick(3);
        rst_n = 1'b1;
        tick(20);
        wb_xfer(1'b0, 16'h0000, 16'h0000, rd);
        check("post_rst_csr", 32'(rd), 32'h0080);
        check("post_rst_irq", 32'(irq), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
